// File: rtl/bcd_updown_counter_n.sv
// bcd_updown_counter_n
//   Multi-decade synchronous up/down BCD counter with clear, checked parallel
//   load, count enable, wrap/saturate limit handling and a cascade-ready
//   terminal count.
//
// Parameters
//   DIGITS   number of BCD decades (1..8); count width is 4*DIGITS
//   WRAP     1 = wrap at the limits, 0 = saturate (hold) at the limits
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   en        count enable
//   x         direction: 0 = up, 1 = down
//   clr       synchronous clear (highest priority)
//   load      synchronous parallel load (beats en)
//   load_val  BCD load value, digit i at [4i+3:4i]; bad nibbles load as 0
//   count     current BCD value, digit 0 least significant
//   tc        combinational terminal count: en & (at all 9s up / all 0s down)
//   ovf       registered pulse on a wrap, or on a blocked count when saturating
//   load_err  registered pulse when a load carried any nibble > 9

// One decade: steps up or down when told to, rolling 9<->0 on its own.
module bcd_digit (
    input  logic [3:0] d,
    input  logic       step,
    input  logic       dn,
    output logic [3:0] nxt
);
    always_comb begin
        nxt = d;
        if (step) begin
            if (dn) nxt = (d == 4'd0) ? 4'd9 : d - 4'd1;
            else    nxt = (d == 4'd9) ? 4'd0 : d + 4'd1;
        end
    end
endmodule

module bcd_updown_counter_n #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  x,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  ovf,
    output logic                  load_err
);
    logic [DIGITS-1:0][3:0] cnt, cnt_nxt, lv, lv_fix;
    logic [DIGITS-1:0]      bad;
    // all9[i] / all0[i]: every digit below i is 9 / 0 (the ripple enable).
    logic [DIGITS:0]        all9, all0;
    logic                   at_lim;

    assign lv      = load_val;
    assign all9[0] = 1'b1;
    assign all0[0] = 1'b1;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_dig
            assign all9[i+1] = all9[i] & (cnt[i] == 4'd9);
            assign all0[i+1] = all0[i] & (cnt[i] == 4'd0);
            assign bad[i]    = lv[i] > 4'd9;
            assign lv_fix[i] = bad[i] ? 4'd0 : lv[i];

            bcd_digit u_dig (
                .d    (cnt[i]),
                .step (x ? all0[i] : all9[i]),
                .dn   (x),
                .nxt  (cnt_nxt[i])
            );
        end
    endgenerate

    // Whole counter sits at the limit for the current direction; the ripple
    // chain already rolls every digit, so wrapping needs no special case.
    assign at_lim = x ? all0[DIGITS] : all9[DIGITS];
    assign tc     = en & at_lim;
    assign count  = cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end else if (clr) begin
            cnt      <= '0;
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            cnt      <= lv_fix;
            ovf      <= 1'b0;
            load_err <= |bad;
        end else if (en) begin
            if (!(at_lim && !WRAP)) cnt <= cnt_nxt;
            ovf      <= at_lim;
            load_err <= 1'b0;
        end else begin
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Bench for bcd_updown_counter_n: two instances (wrap and saturate) share
// stimulus; a decimal-integer model predicts both, checked every cycle, plus
// literal checks for the directed scenarios.
module tb_bcd_updown_counter_n;
    localparam int DIGITS = 4;
    localparam int MAXV   = 9999;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0, x = 1'b0, clr = 1'b0, load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] count1, count0;
    logic tc1, tc0, ovf1, ovf0, le1, le0;

    int n_chk = 0;
    int n_fail = 0;
    bit go = 1'b0;

    // model state: plain decimal integers
    int m1 = 0, m0 = 0;
    bit mo1 = 1'b0, mo0 = 1'b0, mle = 1'b0;

    always #5 clk = ~clk;

    bcd_updown_counter_n #(.DIGITS(DIGITS), .WRAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr(clr), .load(load),
        .load_val(load_val), .count(count1), .tc(tc1), .ovf(ovf1), .load_err(le1));

    bcd_updown_counter_n #(.DIGITS(DIGITS), .WRAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr(clr), .load(load),
        .load_val(load_val), .count(count0), .tc(tc0), .ovf(ovf0), .load_err(le0));

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
        return r;
    endfunction

    function automatic void upd(inout int v, output bit o, output bit le, input bit wrap);
        int nib;
        o = 1'b0;
        le = 1'b0;
        if (clr) v = 0;
        else if (load) begin
            v = 0;
            for (int i = 0; i < DIGITS; i++) begin
                nib = int'(load_val[4*i +: 4]);
                if (nib > 9) le = 1'b1;
                else v += nib * (10 ** i);
            end
        end else if (en) begin
            if (!x) begin
                if (v == MAXV) begin o = 1'b1; if (wrap) v = 0; end
                else v = v + 1;
            end else begin
                if (v == 0) begin o = 1'b1; if (wrap) v = MAXV; end
                else v = v - 1;
            end
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        int v1, v0;
        bit o1, o0, l1, l0;
        if (!rst) begin
            m1 <= 0; m0 <= 0; mo1 <= 1'b0; mo0 <= 1'b0; mle <= 1'b0;
        end else begin
            v1 = m1; v0 = m0;
            upd(v1, o1, l1, 1'b1);
            upd(v0, o0, l0, 1'b0);
            m1 <= v1; m0 <= v0; mo1 <= o1; mo0 <= o0; mle <= l1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (go) begin
            chk("count_w", 32'(count1), 32'(to_bcd(m1)));
            chk("count_s", 32'(count0), 32'(to_bcd(m0)));
            chk("tc_w", 32'(tc1), 32'(en && (x ? m1 == 0 : m1 == MAXV)));
            chk("tc_s", 32'(tc0), 32'(en && (x ? m0 == 0 : m0 == MAXV)));
            chk("ovf_w", 32'(ovf1), 32'(mo1));
            chk("ovf_s", 32'(ovf0), 32'(mo0));
            chk("lerr_w", 32'(le1), 32'(mle));
            chk("lerr_s", 32'(le0), 32'(mle));
        end
    end

    task automatic cyc(input bit c, input bit l, input bit e, input bit xx, input logic [15:0] v);
        clr = c; load = l; en = e; x = xx; load_val = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit rc;
        int r;
        logic [15:0] v;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        go = 1'b1;

        // async reset mid-count
        cyc(0, 1, 0, 0, 16'h0457);
        chk("pre_rst", 32'(count1), 32'h0457);
        cyc(0, 0, 1, 0, 16'h0);
        #2 rst = 1'b0;
        #1;
        chk("rst_count", 32'(count1), 32'h0);
        chk("rst_ovf", 32'(ovf1), 32'h0);
        chk("rst_lerr", 32'(le1), 32'h0);
        chk("rst_model", 32'(m1), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        // up across decades, then wrap at 9999
        cyc(0, 1, 0, 0, 16'h0998);
        cyc(0, 0, 1, 0, 16'h0); chk("up1", 32'(count1), 32'h0999);
        cyc(0, 0, 1, 0, 16'h0); chk("up2", 32'(count1), 32'h1000);
        cyc(0, 0, 1, 0, 16'h0); chk("up3", 32'(count1), 32'h1001);
        chk("up3_model", 32'(to_bcd(m1)), 32'h1001);
        cyc(0, 1, 0, 0, 16'h9999);
        en = 1'b1; x = 1'b0; load = 1'b0; #1;
        chk("tc_at_9999", 32'(tc1), 32'h1);
        cyc(0, 0, 1, 0, 16'h0);
        chk("wrap_up", 32'(count1), 32'h0000);
        chk("wrap_up_ovf", 32'(ovf1), 32'h1);
        chk("sat_up", 32'(count0), 32'h9999);
        chk("sat_up_ovf", 32'(ovf0), 32'h1);
        cyc(0, 0, 0, 0, 16'h0);
        chk("ovf_drop", 32'(ovf1), 32'h0);

        // down across decades, wrap/saturate at 0000
        cyc(0, 1, 0, 1, 16'h1000);
        cyc(0, 0, 1, 1, 16'h0); chk("dn1", 32'(count1), 32'h0999);
        cyc(1, 0, 0, 1, 16'h0);
        cyc(0, 0, 1, 1, 16'h0);
        chk("wrap_dn", 32'(count1), 32'h9999);
        chk("wrap_dn_ovf", 32'(ovf1), 32'h1);
        chk("sat_dn", 32'(count0), 32'h0000);
        cyc(0, 0, 1, 1, 16'h0);
        chk("sat_dn2_ovf", 32'(ovf0), 32'h1);
        chk("sat_dn2", 32'(count0), 32'h0000);
        chk("wrap_dn2", 32'(count1), 32'h9998);
        chk("wrap_dn2_ovf", 32'(ovf1), 32'h0);

        // load with bad nibbles
        cyc(0, 1, 0, 0, 16'h3A7F);
        chk("bad_load", 32'(count1), 32'h3070);
        chk("bad_load_err", 32'(le1), 32'h1);
        cyc(0, 0, 0, 0, 16'h0);
        chk("lerr_drop", 32'(le1), 32'h0);

        // priority clr > load > en
        cyc(0, 1, 0, 0, 16'h0042);
        cyc(1, 1, 1, 0, 16'h0777); chk("clr_prio", 32'(count1), 32'h0000);
        cyc(0, 1, 1, 0, 16'h0123); chk("load_prio", 32'(count1), 32'h0123);

        // direction toggling, then hold
        cyc(0, 1, 0, 0, 16'h0005);
        cyc(0, 0, 1, 0, 16'h0); chk("tog1", 32'(count1), 32'h0006);
        cyc(0, 0, 1, 1, 16'h0); chk("tog2", 32'(count1), 32'h0005);
        cyc(0, 0, 1, 0, 16'h0); chk("tog3", 32'(count1), 32'h0006);
        cyc(0, 0, 1, 1, 16'h0); chk("tog4", 32'(count1), 32'h0005);
        cyc(0, 0, 0, 0, 16'h0);
        cyc(0, 0, 0, 1, 16'h0); chk("hold", 32'(count1), 32'h0005);

        // randomized traffic, biased toward the limits
        for (int n = 0; n < 3000; n++) begin
            rc = ($urandom_range(0, 31) == 0);
            r  = $urandom_range(0, 15);
            case ($urandom_range(0, 5))
                0: v = 16'h9998;
                1: v = 16'h0001;
                2: v = 16'h9999;
                3: v = 16'h0000;
                4: v = 16'($urandom);
                default: v = to_bcd(int'($urandom_range(0, MAXV)));
            endcase
            cyc(rc, r < 2, $urandom_range(0, 3) != 0, 1'($urandom), v);
        end

        go = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
